debug_unit: RTL and testbench
=============================

# debug_unit

Run-control and observation block for the microprogrammed CPU's debug mode. It sits between the board-level debug interface and the CPU top. It gates the CPU's clock enable and supports run, halt, N-instruction step and a parametrised set of PC breakpoints. It also returns a registered view of any one of the CPU's display taps. All halts occur only at instruction boundaries, marked by the command unit's fetch-state pulse.

## Interface
Parameters:
- p_data_width, 16, width of the PC and display taps.
- p_address_width, 10, number of low PC bits compared by breakpoints.
- p_bp_count, 4, number of breakpoint comparators (1..16).
- p_src_count, 8, number of display sources on i_w_disp_bus.
- p_step_width, 8, width of the step counter.

Ports:
- i_w_clk  in  1  single clock; all state changes on its rising edge.
- i_w_reset  in  1  asynchronous, active-low reset.
- i_w_cmd_valid  in  1  command strobe; one command per cycle.
- i_w_cmd  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_ALL, 7 reserved (treated as error).
- i_w_cmd_arg  in  p_data_width  step count for STEP; breakpoint address for SET_BP.
- i_w_cmd_idx  in  clog2(p_bp_count)  breakpoint index for SET_BP and CLR_BP.
- o_w_cmd_ack  out  1  one-cycle pulse, the cycle after a legal command.
- o_w_cmd_err  out  1  one-cycle pulse, the cycle after an illegal command.
- i_w_pc  in  p_data_width  CP register display tap.
- i_w_fetch  in  1  high for exactly one enabled cycle per instruction, in the UC fetch state.
- i_w_disp_bus  in  p_src_count*p_data_width  concatenated display taps; source k occupies bits [k*W +: W].
- i_w_disp_sel  in  clog2(p_src_count)  display source select.
- o_w_disp_out  out  p_data_width  registered selected tap.
- o_w_cpu_en  out  1  CPU clock enable; combinational.
- o_w_halted  out  1  CPU is stopped.
- o_w_bp_hit  out  1  last halt was caused by a breakpoint; sticky until the next RUN or STEP.
- o_w_bp_idx  out  clog2(p_bp_count)  index of the breakpoint that caused the halt.
- o_w_step_left  out  p_step_width  remaining step count.

## Operation
- States: HALTED, RUN, STEP. Reset enters HALTED.
- Reset values: o_w_cpu_en 0, o_w_halted 1, o_w_bp_hit 0, o_w_bp_idx 0, o_w_step_left 0, o_w_disp_out 0, o_w_cmd_ack 0, o_w_cmd_err 0.
- Reset also disarms all breakpoints, zeroes their addresses and clears the pending-halt and skip flags.
- halt_now = i_w_fetch & ~skip & (pending_halt | bp_match | (STEP & step_left==0)).
- o_w_cpu_en = (RUN | STEP) & ~halt_now.
- A halt_now cycle moves the state to HALTED on the next edge, so the fetch microstep never executes.
- bp_match: some armed breakpoint i has addr_i == i_w_pc[p_address_width-1:0]. o_w_bp_idx takes the lowest matching index.
- When both a breakpoint and step exhaustion cause the halt, o_w_bp_hit is set.
- Each enabled fetch (o_w_cpu_en & i_w_fetch) clears skip and, in STEP, decrements step_left.
- RUN (legal only in HALTED):
  - enter RUN; set skip; clear o_w_bp_hit.
  - skip lets the instruction sitting at a breakpoint execute.
- STEP (legal only in HALTED):
  - load step_left = arg[p_step_width-1:0]; a value of 0 loads 1.
  - enter STEP; set skip; clear o_w_bp_hit.
  - Exactly N instructions execute, then the CPU halts at fetch N+1.
- RUN or STEP while in RUN or STEP: ignored, o_w_cmd_err pulses.
- HALT:
  - in RUN or STEP: sets pending_halt; the CPU stops at the next fetch.
  - in HALTED: no-op, ack only.
  - pending_halt clears on entry to HALTED.
- SET_BP, CLR_BP, CLR_ALL: legal in any state.
  - SET_BP loads addr[idx] = arg[p_address_width-1:0] and arms idx.
  - CLR_BP disarms idx; CLR_ALL disarms all.
  - idx >= p_bp_count is an error and changes nothing.
  - The new value is used from the next cycle.
- Display: o_w_disp_out <= slice(i_w_disp_sel); sel >= p_src_count gives 0.

## Timing
- Command-to-effect latency is 1 cycle: state, flags and ack/err update on the edge that samples i_w_cmd_valid.
- Halt latency is 0 cycles: o_w_cpu_en drops in the same cycle as the halting fetch. o_w_halted rises on the following edge.
- A HALT command in the same cycle as a halting fetch: halt by the fetch; pending_halt is not left set.
- A command in the same cycle as the halting fetch is evaluated against the pre-edge state. For example, a STEP in that cycle is an error.
- Display latency is 1 cycle; the display path is independent of run state.
- Reset asserted mid-run forces all outputs to their reset values immediately. Leaving reset, the block is in HALTED with no breakpoints armed.

## Test plan
- Reset, then STEP arg=3 with the fetch pulsed every 4 cycles -> 3 enabled fetches; o_w_cpu_en=0 at the 4th fetch; o_w_halted=1; o_w_step_left=0; bp_hit=0.
- SET_BP idx=2 arg=0x010, then RUN; drive i_w_pc=0x010 at a fetch -> halt that cycle; bp_hit=1, bp_idx=2. A following RUN executes the 0x010 fetch and does not re-halt.
- Arm idx 1 and idx 3 both at 0x020, then RUN and fetch 0x020 -> bp_idx=1. STEP arg=5 with a breakpoint at the 2nd fetch -> halt there, step_left=4, bp_hit=1.
- In RUN, issue HALT mid-instruction -> o_w_cpu_en stays 1 until the next fetch, then 0; a RUN during the pending window -> o_w_cmd_err pulse.
- SET_BP idx=5 (with p_bp_count=4) -> err; cmd 7 -> err. With disp_sel=3 and source 3 = 0xBEEF -> o_w_disp_out=0xBEEF one cycle later; sel=9 -> 0.
- Assert reset mid-STEP -> all outputs at reset values asynchronously; RUN after release with i_w_pc at an old breakpoint address -> no halt.

Source files
------------

// File: rtl/debug_unit_if.sv
// Debug command channel between the board-level debug port and debug_unit.
// The master issues one command per cycle; the slave answers with ack/err.
interface debug_unit_if #(
    parameter int p_data_width = 16,
    parameter int p_bp_count   = 4
);
    // One extra code point so an out-of-range index is expressible.
    localparam int lp_cw = $clog2(p_bp_count + 1);

    logic                    i_w_cmd_valid;
    logic [2:0]              i_w_cmd;
    logic [p_data_width-1:0] i_w_cmd_arg;
    logic [lp_cw-1:0]        i_w_cmd_idx;
    logic                    o_w_cmd_ack;
    logic                    o_w_cmd_err;

    modport master (
        output i_w_cmd_valid, i_w_cmd, i_w_cmd_arg, i_w_cmd_idx,
        input  o_w_cmd_ack, o_w_cmd_err
    );

    modport slave (
        input  i_w_cmd_valid, i_w_cmd, i_w_cmd_arg, i_w_cmd_idx,
        output o_w_cmd_ack, o_w_cmd_err
    );
endinterface

// File: rtl/debug_unit.sv
// Run-control for the microprogrammed CPU: run/halt/step, PC breakpoints,
// and a registered display-tap mux. Halts only at fetch boundaries.
module debug_unit #(
    parameter  int p_data_width    = 16,
    parameter  int p_address_width = 10,
    parameter  int p_bp_count      = 4,
    parameter  int p_src_count     = 8,
    parameter  int p_step_width    = 8,
    localparam int lp_bw = (p_bp_count > 1) ? $clog2(p_bp_count) : 1,
    localparam int lp_cw = $clog2(p_bp_count + 1),
    localparam int lp_sw = $clog2(p_src_count + 1)
) (
    input  logic                                i_w_clk,
    input  logic                                i_w_reset,
    debug_unit_if.slave                         i_cmd_if,
    input  logic [p_data_width-1:0]             i_w_pc,
    input  logic                                i_w_fetch,
    input  logic [p_src_count*p_data_width-1:0] i_w_disp_bus,
    input  logic [lp_sw-1:0]                    i_w_disp_sel,
    output logic [p_data_width-1:0]             o_w_disp_out,
    output logic                                o_w_cpu_en,
    output logic                                o_w_halted,
    output logic                                o_w_bp_hit,
    output logic [lp_bw-1:0]                    o_w_bp_idx,
    output logic [p_step_width-1:0]             o_w_step_left
);
    localparam logic [1:0] S_HALTED = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;

    logic [1:0]                 r_state;
    logic                       r_skip;
    logic                       r_pend;
    logic [p_step_width-1:0]    r_step_left;
    logic                       r_bp_hit;
    logic [lp_bw-1:0]           r_bp_idx;
    logic [p_bp_count-1:0]      r_armed;
    logic [p_address_width-1:0] r_addr [p_bp_count];
    logic [p_data_width-1:0]    r_disp;
    logic                       r_ack;
    logic                       r_err;

    logic                       w_running;
    logic                       w_match;
    logic [lp_bw-1:0]           w_idx;
    logic                       w_halt_now;
    logic                       w_halt_ev;
    logic                       w_fetch_en;
    logic                       w_legal;
    logic                       w_run;
    logic                       w_step;
    logic                       w_halt;
    logic                       w_set;
    logic                       w_clr;
    logic                       w_clra;
    logic                       w_idx_ok;
    logic [p_step_width-1:0]    w_step_arg;
    logic [p_data_width-1:0]    w_disp;
    logic                       w_unused;

    assign w_running = (r_state != S_HALTED);
    assign w_step_arg = i_cmd_if.i_w_cmd_arg[p_step_width-1:0];
    assign w_idx_ok = (32'(i_cmd_if.i_w_cmd_idx) < p_bp_count);
    assign w_unused = ^{i_w_pc, i_cmd_if.i_w_cmd_arg};

    // Scan downward so the lowest matching comparator wins.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int i = p_bp_count - 1; i >= 0; i--) begin
            if (r_armed[i] && r_addr[i] == i_w_pc[p_address_width-1:0]) begin
                w_match = 1'b1;
                w_idx   = lp_bw'(i);
            end
        end
    end

    assign w_halt_now = i_w_fetch & ~r_skip &
                        (r_pend | w_match |
                         ((r_state == S_STEP) && (r_step_left == '0)));
    // A held fetch while already halted must not re-record a breakpoint.
    assign w_halt_ev  = w_halt_now & w_running;
    assign o_w_cpu_en = w_running & ~w_halt_now;
    assign w_fetch_en = o_w_cpu_en & i_w_fetch;

    always_comb begin
        w_legal = 1'b1;
        w_run   = 1'b0;
        w_step  = 1'b0;
        w_halt  = 1'b0;
        w_set   = 1'b0;
        w_clr   = 1'b0;
        w_clra  = 1'b0;
        if (i_cmd_if.i_w_cmd_valid) begin
            case (i_cmd_if.i_w_cmd)
                3'd0: w_legal = 1'b1;
                3'd1: begin
                    w_run   = ~w_running;
                    w_legal = ~w_running;
                end
                3'd2: w_halt = 1'b1;
                3'd3: begin
                    w_step  = ~w_running;
                    w_legal = ~w_running;
                end
                3'd4: begin
                    w_set   = w_idx_ok;
                    w_legal = w_idx_ok;
                end
                3'd5: begin
                    w_clr   = w_idx_ok;
                    w_legal = w_idx_ok;
                end
                3'd6: w_clra = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_disp = '0;
        for (int k = 0; k < p_src_count; k++) begin
            if (i_w_disp_sel == lp_sw'(k))
                w_disp = i_w_disp_bus[k*p_data_width +: p_data_width];
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            r_state     <= S_HALTED;
            r_skip      <= 1'b0;
            r_pend      <= 1'b0;
            r_step_left <= '0;
            r_bp_hit    <= 1'b0;
            r_bp_idx    <= '0;
            r_armed     <= '0;
            r_disp      <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < p_bp_count; i++)
                r_addr[i] <= '0;
        end else begin
            r_ack  <= i_cmd_if.i_w_cmd_valid & w_legal;
            r_err  <= i_cmd_if.i_w_cmd_valid & ~w_legal;
            r_disp <= w_disp;
            if (w_fetch_en) begin
                r_skip <= 1'b0;
                if (r_state == S_STEP)
                    r_step_left <= r_step_left - 1'b1;
            end
            if (w_halt_ev) begin
                r_state  <= S_HALTED;
                r_pend   <= 1'b0;
                r_bp_hit <= w_match;
                if (w_match)
                    r_bp_idx <= w_idx;
            end else if (w_halt && w_running) begin
                r_pend <= 1'b1;
            end
            if (w_run) begin
                r_state  <= S_RUN;
                r_skip   <= 1'b1;
                r_bp_hit <= 1'b0;
            end
            if (w_step) begin
                r_state     <= S_STEP;
                r_skip      <= 1'b1;
                r_bp_hit    <= 1'b0;
                r_step_left <= (w_step_arg == '0) ? p_step_width'(1) : w_step_arg;
            end
            for (int i = 0; i < p_bp_count; i++) begin
                if (w_set && i_cmd_if.i_w_cmd_idx == lp_cw'(i)) begin
                    r_addr[i]  <= i_cmd_if.i_w_cmd_arg[p_address_width-1:0];
                    r_armed[i] <= 1'b1;
                end
                if (w_clra || (w_clr && i_cmd_if.i_w_cmd_idx == lp_cw'(i)))
                    r_armed[i] <= 1'b0;
            end
        end
    end

    assign i_cmd_if.o_w_cmd_ack = r_ack;
    assign i_cmd_if.o_w_cmd_err = r_err;
    assign o_w_halted    = (r_state == S_HALTED);
    assign o_w_bp_hit    = r_bp_hit;
    assign o_w_bp_idx    = r_bp_idx;
    assign o_w_step_left = r_step_left;
    assign o_w_disp_out  = r_disp;
endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: step, breakpoints, halt, errors,
// display mux and asynchronous reset, with an ack/err scoreboard.
module tb_debug_unit;
    localparam int DW = 16;
    localparam int NS = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   pc;
    logic            fetch;
    logic [NS*DW-1:0] bus;
    logic [3:0]      sel;
    logic [DW-1:0]   disp;
    logic            cpu_en;
    logic            halted;
    logic            bp_hit;
    logic [1:0]      bp_idx;
    logic [7:0]      step_left;

    int checks = 0;
    int failures = 0;
    int n_en;
    logic [1:0] sb_q [$];
    logic [1:0] sb_exp;

    always #5 clk = ~clk;

    debug_unit_if #(.p_data_width(DW), .p_bp_count(4)) u_if ();

    debug_unit dut (
        .i_w_clk       (clk),
        .i_w_reset     (rst_n),
        .i_cmd_if      (u_if),
        .i_w_pc        (pc),
        .i_w_fetch     (fetch),
        .i_w_disp_bus  (bus),
        .i_w_disp_sel  (sel),
        .o_w_disp_out  (disp),
        .o_w_cpu_en    (cpu_en),
        .o_w_halted    (halted),
        .o_w_bp_hit    (bp_hit),
        .o_w_bp_idx    (bp_idx),
        .o_w_step_left (step_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        fetch = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one command; ack/err expectation goes through the scoreboard.
    task automatic cmd(input logic [2:0] c, input logic [15:0] arg,
                       input logic [2:0] idx, input logic ack,
                       input logic err);
        u_if.i_w_cmd_valid = 1'b1;
        u_if.i_w_cmd       = c;
        u_if.i_w_cmd_arg   = arg;
        u_if.i_w_cmd_idx   = idx;
        sb_q.push_back({ack, err});
        @(posedge clk);
        #1;
        u_if.i_w_cmd_valid = 1'b0;
        sb_exp = sb_q.pop_front();
        chk("cmd_ack", {31'd0, u_if.o_w_cmd_ack}, {31'd0, sb_exp[1]});
        chk("cmd_err", {31'd0, u_if.o_w_cmd_err}, {31'd0, sb_exp[0]});
    endtask

    task automatic do_fetch(input logic [15:0] a, input logic en);
        pc = a;
        fetch = 1'b1;
        @(negedge clk);
        chk("fetch_cpu_en", {31'd0, cpu_en}, {31'd0, en});
        n_en += int'(cpu_en);
        @(posedge clk);
        #1;
        fetch = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pc = '0;
        fetch = 1'b0;
        sel = '0;
        bus = '0;
        u_if.i_w_cmd_valid = 1'b0;
        u_if.i_w_cmd = '0;
        u_if.i_w_cmd_arg = '0;
        u_if.i_w_cmd_idx = '0;
        n_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_bp_idx", {30'd0, bp_idx}, 32'd0);
        chk("rst_step_left", {24'd0, step_left}, 32'd0);
        chk("rst_disp", {16'd0, disp}, 32'd0);
        chk("rst_ack", {31'd0, u_if.o_w_cmd_ack}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // STEP 3: three fetches execute, the fourth is blocked
        cmd(3'd3, 16'd3, 3'd0, 1'b1, 1'b0);
        for (int f = 1; f <= 4; f++) begin
            idle(3);
            do_fetch(16'(f * 2), (f <= 3));
        end
        chk("step3_enabled", n_en, 32'd3);
        chk("step3_halted", {31'd0, halted}, 32'd1);
        chk("step3_left", {24'd0, step_left}, 32'd0);
        chk("step3_bp_hit", {31'd0, bp_hit}, 32'd0);

        // breakpoint at 0x010, then resume past it
        cmd(3'd4, 16'h010, 3'd2, 1'b1, 1'b0);
        cmd(3'd1, 16'h0, 3'd0, 1'b1, 1'b0);
        idle(2);
        do_fetch(16'h004, 1'b1);
        idle(2);
        do_fetch(16'h010, 1'b0);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        chk("bp_hit", {31'd0, bp_hit}, 32'd1);
        chk("bp_idx", {30'd0, bp_idx}, 32'd2);
        cmd(3'd1, 16'h0, 3'd0, 1'b1, 1'b0);
        chk("resume_bp_hit", {31'd0, bp_hit}, 32'd0);
        do_fetch(16'h010, 1'b1);
        idle(2);
        do_fetch(16'h012, 1'b1);
        chk("resume_running", {31'd0, halted}, 32'd0);

        // HALT mid-instruction, RUN in pending window is an error
        cmd(3'd2, 16'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("pend_cpu_en", {31'd0, cpu_en}, 32'd1);
        @(posedge clk);
        #1;
        cmd(3'd1, 16'h0, 3'd0, 1'b0, 1'b1);
        do_fetch(16'h014, 1'b0);
        chk("pend_halted", {31'd0, halted}, 32'd1);
        cmd(3'd2, 16'h0, 3'd0, 1'b1, 1'b0);

        // two comparators on one address: lowest index reported
        cmd(3'd4, 16'h020, 3'd1, 1'b1, 1'b0);
        cmd(3'd4, 16'h020, 3'd3, 1'b1, 1'b0);
        cmd(3'd1, 16'h0, 3'd0, 1'b1, 1'b0);
        idle(1);
        do_fetch(16'h01E, 1'b1);
        do_fetch(16'h020, 1'b0);
        chk("dual_bp_idx", {30'd0, bp_idx}, 32'd1);
        chk("dual_bp_hit", {31'd0, bp_hit}, 32'd1);

        // STEP 5 interrupted by breakpoint at the second fetch
        cmd(3'd6, 16'h0, 3'd0, 1'b1, 1'b0);
        cmd(3'd4, 16'h030, 3'd0, 1'b1, 1'b0);
        cmd(3'd3, 16'd5, 3'd0, 1'b1, 1'b0);
        idle(1);
        do_fetch(16'h028, 1'b1);
        chk("step5_left1", {24'd0, step_left}, 32'd4);
        idle(1);
        do_fetch(16'h030, 1'b0);
        chk("step5_left", {24'd0, step_left}, 32'd4);
        chk("step5_bp_hit", {31'd0, bp_hit}, 32'd1);
        chk("step5_bp_idx", {30'd0, bp_idx}, 32'd0);

        // illegal commands
        cmd(3'd4, 16'h044, 3'd5, 1'b0, 1'b1);
        cmd(3'd5, 16'h0, 3'd4, 1'b0, 1'b1);
        cmd(3'd7, 16'h0, 3'd0, 1'b0, 1'b1);
        cmd(3'd0, 16'h0, 3'd0, 1'b1, 1'b0);

        // display mux
        for (int k = 0; k < NS; k++)
            bus[k*DW +: DW] = 16'(k * 16'h1111 + 1);
        bus[3*DW +: DW] = 16'hBEEF;
        sel = 4'd3;
        idle(1);
        chk("disp_sel3", {16'd0, disp}, 32'h0000BEEF);
        sel = 4'd9;
        idle(1);
        chk("disp_sel9", {16'd0, disp}, 32'd0);
        sel = 4'd6;
        idle(1);
        chk("disp_sel6", {16'd0, disp}, 32'h00006667);

        // asynchronous reset in the middle of a STEP
        cmd(3'd3, 16'd10, 3'd0, 1'b1, 1'b0);
        idle(1);
        do_fetch(16'h040, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd1);
        chk("arst_step_left", {24'd0, step_left}, 32'd0);
        chk("arst_disp", {16'd0, disp}, 32'd0);
        chk("arst_bp_hit", {31'd0, bp_hit}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cmd(3'd1, 16'h0, 3'd0, 1'b1, 1'b0);
        do_fetch(16'h030, 1'b1);
        idle(1);
        do_fetch(16'h030, 1'b1);
        chk("arst_no_bp", {31'd0, halted}, 32'd0);

        // HALT coincident with a breakpoint fetch leaves nothing pending
        cmd(3'd4, 16'h050, 3'd0, 1'b1, 1'b0);
        u_if.i_w_cmd_valid = 1'b1;
        u_if.i_w_cmd = 3'd2;
        pc = 16'h050;
        fetch = 1'b1;
        sb_q.push_back(2'b10);
        @(negedge clk);
        chk("coinc_cpu_en", {31'd0, cpu_en}, 32'd0);
        @(posedge clk);
        #1;
        u_if.i_w_cmd_valid = 1'b0;
        fetch = 1'b0;
        sb_exp = sb_q.pop_front();
        chk("coinc_ack", {31'd0, u_if.o_w_cmd_ack}, {31'd0, sb_exp[1]});
        chk("coinc_halted", {31'd0, halted}, 32'd1);
        cmd(3'd1, 16'h0, 3'd0, 1'b1, 1'b0);
        do_fetch(16'h050, 1'b1);
        idle(1);
        do_fetch(16'h052, 1'b1);
        chk("coinc_no_pend", {31'd0, halted}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
